// File: rtl/sobel_frame_sink_if.sv
// Pixel-stream input and frame-buffer write port of the Sobel frame sink.
// The slave view belongs to the sink; the master view drives pixels in and observes writes.
interface sobel_frame_sink_if #(
    parameter int ADDR_W = 16
) ();
    logic              ip_flag;
    logic [7:0]        ip_data;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;

    modport master (
        output ip_flag,
        output ip_data,
        input  wr_en,
        input  wr_addr,
        input  wr_data
    );

    modport slave (
        input  ip_flag,
        input  ip_data,
        output wr_en,
        output wr_addr,
        output wr_data
    );
endinterface

// File: rtl/sobel_frame_sink.sv
// Receives the Sobel output stream, writes each pixel into a linear frame buffer
// and reports frame start/done, edge-pixel count and gap-timeout errors.
module sobel_frame_sink #(
    parameter logic [23:0] PIC_W   = 24'd10,
    parameter logic [23:0] PIC_H   = 24'd10,
    parameter int          ADDR_W  = 16,
    parameter logic [15:0] TIMEOUT = 16'd64
) (
    input  logic                 tft_clk,
    input  logic                 tft_rst,
    sobel_frame_sink_if.slave    bus,
    output logic                 frame_start,
    output logic                 frame_done,
    output logic                 frame_err,
    output logic [23:0]          edge_cnt,
    output logic                 busy
);

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    state_t            state_reg, state_next;
    logic [23:0]       col_reg, col_next;
    logic [23:0]       row_reg, row_next;
    logic [15:0]       gap_reg, gap_next;
    logic [23:0]       acc_reg, acc_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [23:0]       edge_cnt_reg, edge_cnt_next;
    logic              wr_en_reg, wr_en_next;
    logic [ADDR_W-1:0] wr_addr_reg, wr_addr_next;
    logic [7:0]        wr_data_reg, wr_data_next;
    logic              start_reg, start_next;
    logic              done_reg, done_next;
    logic              err_reg, err_next;

    logic [ADDR_W-1:0] pix_addr;
    logic [23:0]       acc_pix;
    logic              col_end;
    logic              last_pix;

    // Position registers are zero whenever the FSM rests in IDLE, so the
    // same decode serves pixel 0 and every later pixel of the frame.
    always_comb begin
        pix_addr = (state_reg == IDLE) ? '0 : addr_reg;
        col_end  = (col_reg == PIC_W - 24'd1);
        last_pix = col_end && (row_reg == PIC_H - 24'd1);
        acc_pix  = acc_reg;
        if ((bus.ip_data != 8'd0) && (acc_reg != 24'hFFFFFF)) begin
            acc_pix = acc_reg + 24'd1;
        end
    end

    always_comb begin
        state_next    = state_reg;
        col_next      = col_reg;
        row_next      = row_reg;
        gap_next      = gap_reg;
        acc_next      = acc_reg;
        addr_next     = addr_reg;
        edge_cnt_next = edge_cnt_reg;
        wr_en_next    = 1'b0;
        wr_addr_next  = wr_addr_reg;
        wr_data_next  = wr_data_reg;
        start_next    = 1'b0;
        done_next     = 1'b0;
        err_next      = 1'b0;

        if (bus.ip_flag) begin
            wr_en_next   = 1'b1;
            wr_addr_next = pix_addr;
            wr_data_next = bus.ip_data;
            addr_next    = pix_addr + ADDR_W'(1);
            gap_next     = 16'd0;
            start_next   = (state_reg == IDLE);
            if (last_pix) begin
                done_next     = 1'b1;
                edge_cnt_next = acc_pix;
                acc_next      = 24'd0;
                col_next      = 24'd0;
                row_next      = 24'd0;
                state_next    = IDLE;
            end else begin
                acc_next   = acc_pix;
                state_next = RECV;
                if (col_end) begin
                    col_next = 24'd0;
                    row_next = row_reg + 24'd1;
                end else begin
                    col_next = col_reg + 24'd1;
                end
            end
        end else if (state_reg == RECV) begin
            // A zero TIMEOUT leaves gap frozen so it can never wrap or fire.
            if ((TIMEOUT != 16'd0) && (gap_reg == TIMEOUT - 16'd1)) begin
                err_next   = 1'b1;
                state_next = IDLE;
                col_next   = 24'd0;
                row_next   = 24'd0;
                acc_next   = 24'd0;
                gap_next   = 16'd0;
            end else if (TIMEOUT != 16'd0) begin
                gap_next = gap_reg + 16'd1;
            end
        end
    end

    always_ff @(posedge tft_clk or negedge tft_rst) begin
        if (!tft_rst) begin
            state_reg    <= IDLE;
            col_reg      <= 24'd0;
            row_reg      <= 24'd0;
            gap_reg      <= 16'd0;
            acc_reg      <= 24'd0;
            addr_reg     <= '0;
            edge_cnt_reg <= 24'd0;
            wr_en_reg    <= 1'b0;
            wr_addr_reg  <= '0;
            wr_data_reg  <= 8'd0;
            start_reg    <= 1'b0;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            col_reg      <= col_next;
            row_reg      <= row_next;
            gap_reg      <= gap_next;
            acc_reg      <= acc_next;
            addr_reg     <= addr_next;
            edge_cnt_reg <= edge_cnt_next;
            wr_en_reg    <= wr_en_next;
            wr_addr_reg  <= wr_addr_next;
            wr_data_reg  <= wr_data_next;
            start_reg    <= start_next;
            done_reg     <= done_next;
            err_reg      <= err_next;
        end
    end

    assign bus.wr_en   = wr_en_reg;
    assign bus.wr_addr = wr_addr_reg;
    assign bus.wr_data = wr_data_reg;
    assign frame_start = start_reg;
    assign frame_done  = done_reg;
    assign frame_err   = err_reg;
    assign edge_cnt    = edge_cnt_reg;
    assign busy        = (state_reg == RECV);

endmodule
